// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Formats sb/sw stores into the 4-lane cache byte layout and
//               drains them to the data cache through a DEPTH-entry FIFO.
//               `define STORE_BUF_ADDR_CHECK_EN for per-entry load alias checks.
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic              st_is_word,
    output logic              st_misaligned,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wr_data [0:3],
    output logic [3:0]        mem_byte_en,
    input  logic              mem_ack,
    input  logic [ADDR_W-1:0] ld_check_addr,
    output logic              load_conflict,
    input  logic              halted_in,
    output logic              last_stage_halted
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_WADDR_W = ADDR_W - 2;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // Entry storage: word address, packed lanes {lane3,lane2,lane1,lane0}, byte enables
    logic [c_WADDR_W-1:0] r_ent_addr [0:DEPTH-1];
    logic [31:0]          r_ent_data [0:DEPTH-1];
    logic [3:0]           r_ent_be   [0:DEPTH-1];

    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    state_t               r_state;
    logic                 r_mem_wr_en;
    logic [c_WADDR_W-1:0] r_mem_addr;
    logic [31:0]          r_mem_data;
    logic [3:0]           r_mem_be;

    logic                 r_misaligned;
    logic                 r_halted;
    logic                 r_last_halted;

    logic                 w_is_misaligned;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic [1:0]           w_sb_lane;
    logic [31:0]          w_fmt_data;
    logic [3:0]           w_fmt_be;
    logic [c_WADDR_W-1:0] w_fmt_addr;
    logic [c_PTR_W-1:0]   w_rd_ptr_nxt;
    logic [c_CNT_W-1:0]   w_count_next;

    assign st_ready        = (r_count != c_FULL);
    assign w_is_misaligned = st_is_word && (st_addr[1:0] != 2'b00);
    assign w_accept        = st_valid && st_ready && !r_halted;
    assign w_push          = w_accept && !w_is_misaligned;
    assign w_pop           = (r_state == S_BUSY) && mem_ack;
    assign w_rd_ptr_nxt    = r_rd_ptr + 1'b1;

    // Byte offset b lands in lane 3-b, which is simply the inverted offset
    assign w_sb_lane  = ~st_addr[1:0];
    assign w_fmt_data = st_is_word ? st_data
                                   : ({24'h0, st_data[7:0]} << {w_sb_lane, 3'b000});
    assign w_fmt_be   = st_is_word ? 4'b1111 : (4'b0001 << w_sb_lane);
    assign w_fmt_addr = st_addr[ADDR_W-1:2];

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_ONE;
            2'b01:   w_count_next = r_count - c_ONE;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ent_addr[r_wr_ptr] <= w_fmt_addr;
            r_ent_data[r_wr_ptr] <= w_fmt_data;
            r_ent_be[r_wr_ptr]   <= w_fmt_be;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            r_count <= w_count_next;
        end
    end

    // Write FSM; an empty IDLE buffer forwards the incoming store so the
    // cache request appears the cycle after the push.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mem_wr_en <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_mem_be    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        r_state     <= S_BUSY;
                        r_mem_wr_en <= 1'b1;
                        r_mem_addr  <= r_ent_addr[r_rd_ptr];
                        r_mem_data  <= r_ent_data[r_rd_ptr];
                        r_mem_be    <= r_ent_be[r_rd_ptr];
                    end else if (w_push) begin
                        r_state     <= S_BUSY;
                        r_mem_wr_en <= 1'b1;
                        r_mem_addr  <= w_fmt_addr;
                        r_mem_data  <= w_fmt_data;
                        r_mem_be    <= w_fmt_be;
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        if (r_count > c_ONE) begin
                            r_mem_addr <= r_ent_addr[w_rd_ptr_nxt];
                            r_mem_data <= r_ent_data[w_rd_ptr_nxt];
                            r_mem_be   <= r_ent_be[w_rd_ptr_nxt];
                        end else begin
                            r_state     <= S_IDLE;
                            r_mem_wr_en <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_mem_wr_en <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_misaligned  <= 1'b0;
            r_halted      <= 1'b0;
            r_last_halted <= 1'b0;
        end else begin
            r_misaligned  <= w_accept && w_is_misaligned;
            r_halted      <= r_halted | halted_in;
            r_last_halted <= r_last_halted |
                             ((r_halted | halted_in) && (w_count_next == '0));
        end
    end

    assign st_misaligned     = r_misaligned;
    assign last_stage_halted = r_last_halted;
    assign mem_wr_en         = r_mem_wr_en;
    assign mem_addr          = {r_mem_addr, 2'b00};
    assign mem_byte_en       = r_mem_be;

    generate
        for (genvar gl = 0; gl < 4; gl++) begin : g_lane
            assign mem_wr_data[gl] = r_mem_data[8*gl +: 8];
        end
    endgenerate

`ifdef STORE_BUF_ADDR_CHECK_EN
    logic [DEPTH-1:0] w_hit;

    // An entry is live when its distance from the read pointer is below count
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_addr_cmp
            logic [c_PTR_W-1:0] w_age;
            assign w_age     = c_PTR_W'(gi) - r_rd_ptr;
            assign w_hit[gi] = ({1'b0, w_age} < r_count) &&
                               (r_ent_addr[gi] == ld_check_addr[ADDR_W-1:2]);
        end
    endgenerate

    assign load_conflict = |w_hit;
`else
    logic w_unused_ld_addr;
    assign w_unused_ld_addr = ^ld_check_addr;
    assign load_conflict    = (r_count != '0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Directed self-checking bench for store_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_is_word;
    logic        st_misaligned;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wr_data [0:3];
    logic [3:0]  mem_byte_en;
    logic        mem_ack;
    logic [31:0] ld_check_addr;
    logic        load_conflict;
    logic        halted_in;
    logic        last_stage_halted;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic [3:0]  log_be   [$];

    store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .st_valid          (st_valid),
        .st_ready          (st_ready),
        .st_addr           (st_addr),
        .st_data           (st_data),
        .st_is_word        (st_is_word),
        .st_misaligned     (st_misaligned),
        .mem_wr_en         (mem_wr_en),
        .mem_addr          (mem_addr),
        .mem_wr_data       (mem_wr_data),
        .mem_byte_en       (mem_byte_en),
        .mem_ack           (mem_ack),
        .ld_check_addr     (ld_check_addr),
        .load_conflict     (load_conflict),
        .halted_in         (halted_in),
        .last_stage_halted (last_stage_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lanes();
        return {mem_wr_data[3], mem_wr_data[2], mem_wr_data[1], mem_wr_data[0]};
    endfunction

    // Completed cache writes, in the order the cache accepts them
    always @(posedge clk) begin
        if (!reset && mem_wr_en && mem_ack) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(lanes());
            log_be.push_back(mem_byte_en);
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic w);
        st_valid   = 1'b1;
        st_addr    = a;
        st_data    = d;
        st_is_word = w;
        tick();
        st_valid   = 1'b0;
    endtask

    task automatic drain(input string tag);
        mem_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!mem_wr_en) break;
        end
        mem_ack = 1'b0;
        check(tag, mem_wr_en, 1'b0);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_be.delete();
    endtask

    initial begin
        logic exp_conf;
        reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_is_word = 1'b0;
        mem_ack = 1'b0; ld_check_addr = '0; halted_in = 1'b0;
        tick(); tick();
        reset = 1'b0;

        check("rst_ready", st_ready, 1'b1);
        check("rst_wr_en", mem_wr_en, 1'b0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_data", lanes(), 32'h0);
        check("rst_be", mem_byte_en, 4'h0);
        check("rst_mis", st_misaligned, 1'b0);
        check("rst_conf", load_conflict, 1'b0);
        check("rst_halt", last_stage_halted, 1'b0);

        // 1: single aligned sw
        clear_log();
        push(32'h100, 32'hAABBCCDD, 1'b1);
        check("sw_wr_en", mem_wr_en, 1'b1);
        check("sw_addr", mem_addr, 32'h100);
        check("sw_lanes", lanes(), 32'hAABBCCDD);
        check("sw_be", mem_byte_en, 4'b1111);
        drain("sw_drain");
        check("sw_nwrites", log_addr.size(), 1);

        // 2: sb at offsets 3 and 0
        push(32'h203, 32'h1234565A, 1'b0);
        check("sb3_addr", mem_addr, 32'h200);
        check("sb3_lanes", lanes(), 32'h0000005A);
        check("sb3_be", mem_byte_en, 4'b0001);
        drain("sb3_drain");
        push(32'h200, 32'h0000005A, 1'b0);
        check("sb0_lanes", lanes(), 32'h5A000000);
        check("sb0_be", mem_byte_en, 4'b1000);
        drain("sb0_drain");

        // 3: fill to DEPTH with the cache stalled
        clear_log();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("fill_ready%0d", k), st_ready, (k < 4) ? 1'b1 : 1'b0);
            push(32'h400 + 32'(4*k), 32'h11111111 * 32'(k + 1), 1'b1);
        end
        check("full_ready", st_ready, 1'b0);
        check("full_head", mem_addr, 32'h400);
        mem_ack = 1'b1;
        tick();
        check("pop_ready", st_ready, 1'b1);
        check("pop_next", mem_addr, 32'h404);
        drain("fill_drain");
        check("fill_nwrites", log_addr.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < log_addr.size()) begin
                check($sformatf("fill_addr%0d", k), log_addr[k], 32'h400 + 32'(4*k));
                check($sformatf("fill_data%0d", k), log_data[k], 32'h11111111 * 32'(k + 1));
            end
        end

        // 4: misaligned sw is dropped
        clear_log();
        push(32'h102, 32'hDEADBEEF, 1'b1);
        check("mis_pulse", st_misaligned, 1'b1);
        check("mis_wr_en", mem_wr_en, 1'b0);
        check("mis_conf", load_conflict, 1'b0);
        tick();
        check("mis_pulse_end", st_misaligned, 1'b0);
        check("mis_wr_en2", mem_wr_en, 1'b0);
        check("mis_nwrites", log_addr.size(), 0);

        // 5: simultaneous push and pop, then reset while busy
        push(32'h500, 32'hA0A0A0A0, 1'b1);
        push(32'h504, 32'hB0B0B0B0, 1'b1);
        st_valid = 1'b1; st_addr = 32'h508; st_data = 32'hC0C0C0C0; st_is_word = 1'b1;
        mem_ack  = 1'b1;
        tick();
        st_valid = 1'b0;
        check("pp_head", mem_addr, 32'h504);
        check("pp_wr_en", mem_wr_en, 1'b1);
        drain("pp_drain");
        check("pp_nwrites", log_addr.size(), 3);
        if (log_addr.size() == 3) begin
            check("pp_ord0", log_addr[0], 32'h500);
            check("pp_ord1", log_addr[1], 32'h504);
            check("pp_ord2", log_addr[2], 32'h508);
        end
        push(32'h600, 32'h1, 1'b1);
        push(32'h604, 32'h2, 1'b1);
        check("rb_busy", mem_wr_en, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rb_wr_en", mem_wr_en, 1'b0);
        check("rb_ready", st_ready, 1'b1);
        tick(); tick();
        check("rb_discard", mem_wr_en, 1'b0);

        // 6: load alias check and halt drain
        clear_log();
`ifdef STORE_BUF_ADDR_CHECK_EN
        exp_conf = 1'b0;
`else
        exp_conf = 1'b1;
`endif
        push(32'h300, 32'h33333333, 1'b1);
        ld_check_addr = 32'h304;
        #1;
        check("conf_other_word", load_conflict, exp_conf);
        ld_check_addr = 32'h302;
        #1;
        check("conf_same_word", load_conflict, 1'b1);
        halted_in = 1'b1;
        tick();
        halted_in = 1'b0;
        check("halt_pending", last_stage_halted, 1'b0);
        push(32'h700, 32'h77777777, 1'b1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("halt_drained", last_stage_halted, 1'b1);
        check("halt_wr_en", mem_wr_en, 1'b0);
        tick(); tick();
        check("halt_ignored", mem_wr_en, 1'b0);
        check("halt_held", last_stage_halted, 1'b1);
        check("halt_nwrites", log_addr.size(), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("halt_rst", last_stage_halted, 1'b0);
        halted_in = 1'b1;
        tick();
        halted_in = 1'b0;
        check("halt_empty", last_stage_halted, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
